// File: rtl/cdc_gray_src_multi_if.sv
// Source-side valid/ready bundle for cdc_gray_src_multi: one lane per channel,
// payload for channel c at src_data[c*DataWidth +: DataWidth].
interface cdc_gray_src_multi_if #(
  parameter int unsigned NumChan   = 4,
  parameter int unsigned DataWidth = 32
);

  logic [NumChan*DataWidth-1:0] src_data;
  logic [NumChan-1:0]           src_valid;
  logic [NumChan-1:0]           src_ready;

  modport master (
    output src_data,
    output src_valid,
    input  src_ready
  );

  modport slave (
    input  src_data,
    input  src_valid,
    output src_ready
  );

endinterface

// File: rtl/cdc_gray_src_multi.sv
// Source-domain half of a multi-channel gray-pointer async FIFO.
// Optional feature macro: CDC_SRC_SPILL_EN (2-entry spill register in front of each FIFO).
module cdc_gray_src_multi #(
  parameter int unsigned NumChan    = 4,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned LogDepth   = 2,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned AfullThr   = 3
) (
  input  logic                                          src_clk_i,
  input  logic                                          src_rst_i,
  cdc_gray_src_multi_if.slave                           src_io,
  output logic [NumChan*(LogDepth+1)-1:0]               level_o,
  output logic [NumChan-1:0]                            almost_full_o,
  output logic [NumChan*(2**LogDepth)*DataWidth-1:0]    async_data_o,
  output logic [NumChan*(LogDepth+1)-1:0]               async_wptr_o,
  input  logic [NumChan*(LogDepth+1)-1:0]               async_rptr_i
);

  localparam int unsigned Depth = 2 ** LogDepth;
  localparam int unsigned PtrW  = LogDepth + 1;

  typedef logic [PtrW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PtrW-1] = g[PtrW-1];
    for (int i = int'(PtrW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    ptr_t                 wb_q, wb_d, wg_q;
    ptr_t                 rs, rb, lvl;
    ptr_t                 sync_q [SyncStages];
    logic [DataWidth-1:0] mem_q  [Depth];
    logic [DataWidth-1:0] in_data, wr_data;
    logic                 in_valid, full, wr_en;

    assign in_data  = src_io.src_data[c*DataWidth +: DataWidth];
    assign in_valid = src_io.src_valid[c];

    // Plain flop chain: no logic between synchroniser stages.
    always_ff @(posedge src_clk_i or posedge src_rst_i) begin
      if (src_rst_i) begin
        for (int i = 0; i < int'(SyncStages); i++) begin
          sync_q[i] <= '0;
        end
      end else begin
        sync_q[0] <= async_rptr_i[c*PtrW +: PtrW];
        for (int i = 1; i < int'(SyncStages); i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign rs = sync_q[SyncStages-1];
    assign rb = gray2bin(rs);

    // Full when the gray write pointer is exactly one lap ahead of the synced read pointer.
    if (LogDepth == 1) begin : g_full_d2
      assign full = (wg_q == ~rs);
    end else begin : g_full_dn
      assign full = (wg_q == {~rs[PtrW-1 -: 2], rs[PtrW-3:0]});
    end

`ifdef CDC_SRC_SPILL_EN
    logic [DataWidth-1:0] sp_q [2];
    logic [DataWidth-1:0] sp_d [2];
    logic [1:0]           cnt_q, cnt_d;
    logic                 sp_push;

    // Ready only reflects spill occupancy, decoupling it from the synced rptr.
    assign src_io.src_ready[c] = (cnt_q != 2'd2);
    assign sp_push             = in_valid && (cnt_q != 2'd2);
    assign wr_en               = (cnt_q != 2'd0) && !full;
    assign wr_data             = sp_q[0];

    always_comb begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
      if (wr_en) begin
        sp_d[0] = sp_q[1];
        cnt_d   = cnt_q - 2'd1;
      end
      if (sp_push) begin
        sp_d[cnt_d[0]] = in_data;
        cnt_d          = cnt_d + 2'd1;
      end
    end

    always_ff @(posedge src_clk_i or posedge src_rst_i) begin
      if (src_rst_i) begin
        sp_q[0] <= '0;
        sp_q[1] <= '0;
        cnt_q   <= '0;
      end else begin
        sp_q  <= sp_d;
        cnt_q <= cnt_d;
      end
    end
`else
    assign src_io.src_ready[c] = !full;
    assign wr_en               = in_valid && !full;
    assign wr_data             = in_data;
`endif

    assign wb_d = wb_q + ptr_t'(wr_en);

    // Gray pointer is registered from the next binary value so async_wptr_o has no comb path.
    always_ff @(posedge src_clk_i or posedge src_rst_i) begin
      if (src_rst_i) begin
        wb_q <= '0;
        wg_q <= '0;
      end else begin
        wb_q <= wb_d;
        wg_q <= bin2gray(wb_d);
      end
    end

    always_ff @(posedge src_clk_i or posedge src_rst_i) begin
      if (src_rst_i) begin
        for (int s = 0; s < int'(Depth); s++) begin
          mem_q[s] <= '0;
        end
      end else if (wr_en) begin
        mem_q[wb_q[LogDepth-1:0]] <= wr_data;
      end
    end

    assign lvl                           = wb_q - rb;
    assign level_o[c*PtrW +: PtrW]       = lvl;
    assign almost_full_o[c]              = (32'(lvl) >= AfullThr);
    assign async_wptr_o[c*PtrW +: PtrW]  = wg_q;

    for (genvar s = 0; s < Depth; s++) begin : g_slot
      assign async_data_o[(c*Depth+s)*DataWidth +: DataWidth] = mem_q[s];
    end
  end

endmodule
